mem_stage_ctrl: RTL and testbench

Memory-stage access controller that consumes the EX/MEM pipeline register outputs (MEM_RD, MEM_WR, w_h, DIR, DI) and turns them into a handshaked request to the data memory. It places halfword data on the correct byte lanes and holds the pipeline with a stall while the memory is busy. It returns aligned and sign-extended read data for the MEM/WB register. Errors are flagged for misaligned accesses, contradictory controls and memory timeouts.

---
 rtl/mem_stage_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: turns EX/MEM load/store controls into a
// req/ack handshake to data memory. It places halfword store data on the
// correct byte lanes and stalls the pipeline while the access is in flight.
// It returns aligned, sign-extended load data for the MEM/WB register.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        reloj,
  input  logic        resetMEM,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic        w_h,
  input  logic [31:0] DIR,
  input  logic [31:0] DI,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_mem,
  output logic [31:0] DO,
  output logic        err_mem
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              hw_q, hw_d;
  logic              hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       do_q, do_d;
  logic              err_q, err_d;
  logic              stall_raw;

  logic              access;
  logic              misaligned;
  logic              bad;

  // Byte enables for a word or for the halfword lane picked by address bit 1
  function automatic logic [3:0] lane_be(input logic hw, input logic hi);
    if (!hw) return 4'b1111;
    return hi ? 4'b1100 : 4'b0011;
  endfunction

  // Store data shifted onto the lanes enabled by lane_be
  function automatic logic [31:0] lane_wdata(input logic hw, input logic hi,
                                             input logic [31:0] d);
    if (!hw) return d;
    return hi ? {d[15:0], 16'h0000} : {16'h0000, d[15:0]};
  endfunction

  // Load data: full word, or the selected halfword sign-extended to 32 bits
  function automatic logic [31:0] load_extract(input logic hw, input logic hi,
                                               input logic [31:0] r);
    logic [15:0] h;
    h = hi ? r[31:16] : r[15:0];
    return hw ? {{16{h[15]}}, h} : r;
  endfunction

  assign access     = MEM_RD ^ MEM_WR;
  assign misaligned = w_h ? DIR[0] : (DIR[1:0] != 2'b00);
  assign bad        = (MEM_RD & MEM_WR) | (access & misaligned);

  // Next-state, request latching, timeout counting and load-data capture
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    hw_d      = hw_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    do_d      = do_q;
    err_d     = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (bad) begin
          // Faulty instruction flows through without touching memory
          err_d = 1'b1;
        end else if (access) begin
          stall_raw = 1'b1;
          req_d     = 1'b1;
          we_d      = MEM_WR;
          addr_d    = {DIR[31:2], 2'b00};
          wdata_d   = lane_wdata(w_h, DIR[1], DI);
          be_d      = lane_be(w_h, DIR[1]);
          hw_d      = w_h;
          hi_d      = DIR[1];
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        if (mem_ack) begin
          // Ack on the last count still completes cleanly
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) do_d = load_extract(hw_q, hi_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Pipeline advances at the end of this cycle; never re-issue
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge reloj or negedge resetMEM) begin
    if (!resetMEM) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      hw_q    <= 1'b0;
      hi_q    <= 1'b0;
      cnt_q   <= '0;
      do_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      hw_q    <= hw_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

  // Stall is forced low while reset is held, whatever the inputs request
  assign stall_mem = resetMEM & stall_raw;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign DO        = do_q;
  assign err_mem   = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios followed by randomized
// accesses, each checked against a behavioural model of the memory stage.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT_CYC = 16;

  logic        reloj;
  logic        resetMEM;
  logic        MEM_RD;
  logic        MEM_WR;
  logic        w_h;
  logic [31:0] DIR;
  logic [31:0] DI;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_mem;
  logic [31:0] DO;
  logic        err_mem;

  int          n_pass;
  int          n_total;
  logic [31:0] model_do;

  mem_stage_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .reloj     (reloj),
    .resetMEM  (resetMEM),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .w_h       (w_h),
    .DIR       (DIR),
    .DI        (DI),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_mem (stall_mem),
    .DO        (DO),
    .err_mem   (err_mem)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference result of a load, from the address/width rules
  function automatic logic [31:0] model_load(input logic wh, input logic [31:0] dir,
                                             input logic [31:0] rdata);
    int unsigned half;
    if (!wh) return rdata;
    half = (rdata >> (16 * dir[1])) & 32'h0000_FFFF;
    if (half >= 32'h8000) return half | 32'hFFFF_0000;
    return half;
  endfunction

  // One instruction through the memory stage; starts and ends 1 ns after a
  // rising edge. ack_dly = cycles after mem_req rises before mem_ack
  // (>= TIMEOUT_CYC means the memory never answers).
  task automatic run_access(input logic rd, input logic wr, input logic wh,
                            input logic [31:0] dir, input logic [31:0] di,
                            input logic [31:0] rdata, input int ack_dly);
    logic        acc, bad, mis, tmo;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          stalls, reqs;
    mis = wh ? dir[0] : (dir[1:0] != 2'b00);
    acc = rd ^ wr;
    bad = (rd & wr) | (acc & mis);
    tmo = (ack_dly >= TIMEOUT_CYC);
    MEM_RD = rd; MEM_WR = wr; w_h = wh; DIR = dir; DI = di;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    if (!acc || bad) begin
      check("noissue_stall", {31'b0, stall_mem}, 32'd0);
      @(posedge reloj); #1;
      check("noissue_err", {31'b0, err_mem}, {31'b0, bad});
      check("noissue_req", {31'b0, mem_req}, 32'd0);
      MEM_RD = 1'b0; MEM_WR = 1'b0;
      @(posedge reloj); #1;
      check("err_pulse_end", {31'b0, err_mem}, 32'd0);
      check("noissue_do", DO, model_do);
      return;
    end
    exp_addr  = dir & 32'hFFFF_FFFC;
    exp_be    = wh ? 4'(3 << (2 * dir[1])) : 4'hF;
    exp_wdata = wh ? ((di & 32'h0000_FFFF) << (16 * dir[1])) : di;
    stalls = stall_mem ? 1 : 0;
    reqs   = 0;
    @(posedge reloj); #1;
    check("req_rise", {31'b0, mem_req}, 32'd1);
    check("req_we", {31'b0, mem_we}, {31'b0, wr});
    check("req_addr", mem_addr, exp_addr);
    check("req_be", {28'b0, mem_be}, {28'b0, exp_be});
    check("req_wdata", mem_wdata, exp_wdata);
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      // Inputs wander during the wait; the latched access must not care
      MEM_RD = 1'($urandom); MEM_WR = 1'($urandom); w_h = 1'($urandom);
      DIR = $urandom; DI = $urandom;
      if (k == ack_dly) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rdata = $urandom;
      end
      #1;
      if (stall_mem) stalls++;
      if (mem_req) reqs++;
      @(posedge reloj); #1;
      mem_ack = 1'b0;
      if (k == ack_dly) break;
    end
    // Completion cycle: stray ack here must be ignored
    MEM_RD = 1'b0; MEM_WR = 1'b0;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1;
    if (rd && !tmo) model_do = model_load(wh, dir, rdata);
    check("done_stall", {31'b0, stall_mem}, 32'd0);
    check("done_req", {31'b0, mem_req}, 32'd0);
    check("done_err", {31'b0, err_mem}, {31'b0, tmo});
    check("done_do", DO, model_do);
    check("stall_cycles", stalls, tmo ? TIMEOUT_CYC + 1 : ack_dly + 2);
    check("req_cycles", reqs, tmo ? TIMEOUT_CYC : ack_dly + 1);
    @(posedge reloj); #1;
    mem_ack = 1'b0;
    #1;
    check("idle_stall", {31'b0, stall_mem}, 32'd0);
    check("idle_req", {31'b0, mem_req}, 32'd0);
    check("idle_err", {31'b0, err_mem}, 32'd0);
    check("idle_do", DO, model_do);
  endtask

  initial begin
    n_pass = 0; n_total = 0; model_do = 32'h0;
    resetMEM = 1'b0;
    MEM_RD = 1'b0; MEM_WR = 1'b0; w_h = 1'b0; DIR = '0; DI = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'b0, mem_be}, 32'd0);
    check("rst_do", DO, 32'd0);
    check("rst_err", {31'b0, err_mem}, 32'd0);
    check("rst_stall", {31'b0, stall_mem}, 32'd0);
    resetMEM = 1'b1;
    @(posedge reloj); #1;

    // Directed scenarios
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
    run_access(1'b0, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_ABCD, 32'h0, 1);
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
    check("hw_load_hi", DO, 32'hFFFF_8001);
    run_access(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 2);
    check("hw_load_lo", DO, 32'h0000_7FFF);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'h1234_5678, 1000);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0034, 32'h0, 32'hCAFE_F00D, TIMEOUT_CYC - 1);
    run_access(1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0);
    run_access(1'b0, 1'b1, 1'b1, 32'h0000_0041, 32'h5555_5555, 32'h0, 0);
    run_access(1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0, 0);

    // Asynchronous reset while waiting for the memory
    MEM_RD = 1'b1; MEM_WR = 1'b0; w_h = 1'b0; DIR = 32'h0000_0080;
    @(posedge reloj); #1;
    check("pre_rst_req", {31'b0, mem_req}, 32'd1);
    @(posedge reloj); #2;
    resetMEM = 1'b0;
    #1;
    model_do = 32'h0;
    check("arst_req", {31'b0, mem_req}, 32'd0);
    check("arst_stall", {31'b0, stall_mem}, 32'd0);
    check("arst_do", DO, 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    MEM_RD = 1'b0;
    @(negedge reloj);
    resetMEM = 1'b1;
    @(posedge reloj); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge reloj); #1;
    mem_ack = 1'b0;
    check("late_ack_req", {31'b0, mem_req}, 32'd0);
    check("late_ack_do", DO, 32'd0);
    check("late_ack_stall", {31'b0, stall_mem}, 32'd0);
    check("late_ack_err", {31'b0, err_mem}, 32'd0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      logic        r_rd, r_wr, r_wh;
      logic [31:0] r_dir, r_di, r_rdata;
      int          r_dly;
      r_rd  = 1'($urandom);
      r_wr  = ($urandom_range(0, 3) == 0) ? r_rd : ~r_rd;
      r_wh  = 1'($urandom);
      r_dir = $urandom;
      if ($urandom_range(0, 3) != 0) r_dir[0] = 1'b0;
      if (!r_wh && $urandom_range(0, 3) != 0) r_dir[1] = 1'b0;
      r_di    = $urandom;
      r_rdata = $urandom;
      r_dly   = $urandom_range(0, TIMEOUT_CYC + 2);
      run_access(r_rd, r_wr, r_wh, r_dir, r_di, r_rdata, r_dly);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
